// File: rtl/pipe_pkg.sv
// Shared pipeline definitions: PC-source encodings, IF-stage state type and the bubble word.
package pipe_pkg;

    localparam logic [1:0] PCSRC_SEQ = 2'b00;
    localparam logic [1:0] PCSRC_BR  = 2'b01;
    localparam logic [1:0] PCSRC_REG = 2'b10;
    localparam logic [1:0] PCSRC_JMP = 2'b11;

    typedef enum logic [1:0] {
        RUN,
        HOLD,
        DISCARD
    } if_state_t;

    localparam logic [31:0] NOP_WORD = 32'h0000_0000;

endpackage

// File: rtl/pipe_if_stage_if.sv
// Instruction-memory fetch bus: req/addr towards memory, ack/rdata back.
interface pipe_if_stage_if;

    logic        req;
    logic [31:0] addr;
    logic        ack;
    logic [31:0] rdata;

    modport master (output req, output addr, input ack, input rdata);
    modport slave  (input req, input addr, output ack, output rdata);

endinterface

// File: rtl/pipe_if_next_pc.sv
// Combinational next-PC select between sequential, branch, register and jump targets.
module pipe_if_next_pc
    import pipe_pkg::*;
(
    input  logic [1:0]  pcsource,
    input  logic [31:0] pc4,
    input  logic [31:0] bpc,
    input  logic [31:0] rpc,
    input  logic [31:0] jpc,
    output logic [31:0] next_pc
);

    always_comb begin
        next_pc = pc4;
        case (pcsource)
            PCSRC_BR:  next_pc = bpc;
            PCSRC_REG: next_pc = rpc;
            PCSRC_JMP: next_pc = jpc;
            default:   next_pc = pc4;
        endcase
    end

endmodule

// File: rtl/pipe_if_stage.sv
// Instruction-fetch stage with variable-latency imem handshake and ID-stage stall.
// Optional performance counters are enabled with the PIPE_IF_PERF_EN macro.
module pipe_if_stage
    import pipe_pkg::*;
#(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter logic [31:0] NOP_INS  = NOP_WORD
) (
    input  logic              clock,
    input  logic              resetn,
    input  logic              wpcir,
    input  logic [1:0]        pcsource,
    input  logic [31:0]       bpc,
    input  logic [31:0]       rpc,
    input  logic [31:0]       jpc,
    pipe_if_stage_if.master   imem,
    output logic [31:0]       pc,
    output logic [31:0]       pc4,
    output logic [31:0]       ins,
    output logic              flush
`ifdef PIPE_IF_PERF_EN
    ,
    output logic [31:0]       fetch_cnt,
    output logic [31:0]       bubble_cnt
`endif
);

    if_state_t   state;
    logic [31:0] hold_buf;
    logic [31:0] redir_pc;
    logic [31:0] next_pc;
    logic        redirect;

    assign pc4      = pc + 32'd4;
    assign redirect = wpcir && (pcsource != PCSRC_SEQ);

    pipe_if_next_pc u_next_pc (
        .pcsource (pcsource),
        .pc4      (pc4),
        .bpc      (bpc),
        .rpc      (rpc),
        .jpc      (jpc),
        .next_pc  (next_pc)
    );

    // The address is held at pc in every requesting state so it cannot move before ack.
    always_comb begin
        imem.req  = 1'b1;
        imem.addr = pc;
        ins       = NOP_INS;
        flush     = 1'b0;
        case (state)
            RUN: begin
                if (imem.ack) begin
                    ins   = imem.rdata;
                    flush = redirect;
                end
            end
            HOLD: begin
                imem.req = 1'b0;
                ins      = hold_buf;
                flush    = redirect;
            end
            default: begin
                ins   = NOP_INS;
                flush = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clock) begin
        if (!resetn) begin
            state    <= RUN;
            pc       <= RESET_PC;
            hold_buf <= '0;
            redir_pc <= '0;
        end else begin
            case (state)
                RUN: begin
                    if (imem.ack && wpcir) begin
                        pc <= next_pc;
                    end else if (imem.ack) begin
                        hold_buf <= imem.rdata;
                        state    <= HOLD;
                    end else if (redirect) begin
                        redir_pc <= next_pc;
                        state    <= DISCARD;
                    end
                end
                HOLD: begin
                    if (wpcir) begin
                        pc    <= next_pc;
                        state <= RUN;
                    end
                end
                DISCARD: begin
                    // The in-flight word belongs to the abandoned path; the latest redirect wins.
                    if (imem.ack) begin
                        pc    <= redirect ? next_pc : redir_pc;
                        state <= RUN;
                    end else if (redirect) begin
                        redir_pc <= next_pc;
                    end
                end
                default: state <= RUN;
            endcase
        end
    end

`ifdef PIPE_IF_PERF_EN
    logic delivered;

    assign delivered = (state == HOLD) || ((state == RUN) && imem.ack);

    always_ff @(posedge clock) begin
        if (!resetn) begin
            fetch_cnt  <= '0;
            bubble_cnt <= '0;
        end else begin
            if (wpcir && delivered && !flush) begin
                fetch_cnt <= fetch_cnt + 32'd1;
            end
            if (wpcir && !delivered) begin
                bubble_cnt <= bubble_cnt + 32'd1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_pipe_if_stage.sv
// Self-checking bench for pipe_if_stage: directed scenarios then randomized traffic vs a rule-level model.
module tb_pipe_if_stage;
    import pipe_pkg::*;

    logic        clock = 1'b0;
    logic        resetn;
    logic        wpcir;
    logic [1:0]  pcsource;
    logic [31:0] bpc, rpc, jpc;
    logic [31:0] pc, pc4, ins;
    logic        flush;
`ifdef PIPE_IF_PERF_EN
    logic [31:0] fetch_cnt, bubble_cnt;
`endif

    pipe_if_stage_if imem_bus ();

    always #5 clock = ~clock;

    pipe_if_stage dut (
        .clock    (clock),
        .resetn   (resetn),
        .wpcir    (wpcir),
        .pcsource (pcsource),
        .bpc      (bpc),
        .rpc      (rpc),
        .jpc      (jpc),
        .imem     (imem_bus),
        .pc       (pc),
        .pc4      (pc4),
        .ins      (ins),
        .flush    (flush)
`ifdef PIPE_IF_PERF_EN
        ,
        .fetch_cnt  (fetch_cnt),
        .bubble_cnt (bubble_cnt)
`endif
    );

    int checks   = 0;
    int failures = 0;

    // Reference model: fetch PC, a captured word waiting for ID, a pending redirect behind an abandoned fetch.
    logic [31:0] m_pc, m_held_word, m_drop_target, m_fetch, m_bubble;
    bit          m_held, m_drop, m_known;

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return (a * 32'h9E37_79B1) ^ 32'h1357_9BDF;
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("[TB] FAIL %s observed=%08h expected=%08h", tag, obs, exp);
        end
    endtask

    task automatic after_edge();
        @(posedge clock);
        #1;
    endtask

    task automatic step(input bit rst_n, input bit w, input logic [1:0] src,
                        input logic [31:0] tgt, input bit ack);
        bit          redir, exp_req, exp_flush, delivered;
        logic [31:0] exp_ins, word;
        @(negedge clock);
        resetn   = rst_n;
        wpcir    = w;
        pcsource = src;
        bpc      = (src == PCSRC_BR)  ? tgt : tgt ^ 32'h10;
        rpc      = (src == PCSRC_REG) ? tgt : tgt ^ 32'h20;
        jpc      = (src == PCSRC_JMP) ? tgt : tgt ^ 32'h40;
        word     = mem_word(m_pc);
        imem_bus.ack   = ack;
        imem_bus.rdata = word;
        #1;
        redir = w && (src != 2'b00);
        if (m_held) begin
            exp_req = 0; exp_ins = m_held_word; exp_flush = redir; delivered = 1;
        end else if (m_drop) begin
            exp_req = 1; exp_ins = NOP_WORD; exp_flush = 0; delivered = 0;
        end else begin
            exp_req = 1; exp_ins = ack ? word : NOP_WORD; exp_flush = ack && redir; delivered = ack;
        end
        if (m_known) begin
            check("pc", pc, m_pc);
            check("pc4", pc4, m_pc + 32'd4);
            check("req", {31'b0, imem_bus.req}, {31'b0, exp_req});
            if (exp_req) check("addr", imem_bus.addr, m_pc);
            check("ins", ins, exp_ins);
            check("flush", {31'b0, flush}, {31'b0, exp_flush});
`ifdef PIPE_IF_PERF_EN
            check("fetch_cnt", fetch_cnt, m_fetch);
            check("bubble_cnt", bubble_cnt, m_bubble);
`endif
        end
        if (!rst_n) begin
            m_pc = 32'h0; m_held = 0; m_drop = 0; m_fetch = 0; m_bubble = 0; m_known = 1;
        end else if (m_known) begin
            if (w && delivered && !exp_flush) m_fetch++;
            if (w && !delivered) m_bubble++;
            if (m_held) begin
                if (w) begin
                    m_pc   = redir ? tgt : m_pc + 32'd4;
                    m_held = 0;
                end
            end else if (m_drop) begin
                if (ack) begin
                    m_pc   = redir ? tgt : m_drop_target;
                    m_drop = 0;
                end else if (redir) begin
                    m_drop_target = tgt;
                end
            end else if (ack && w) begin
                m_pc = redir ? tgt : m_pc + 32'd4;
            end else if (ack) begin
                m_held = 1; m_held_word = word;
            end else if (redir) begin
                m_drop = 1; m_drop_target = tgt;
            end
        end
    endtask

    initial begin
        int guard;
        m_known = 0; m_held = 0; m_drop = 0;
        m_pc = 0; m_fetch = 0; m_bubble = 0; m_held_word = 0; m_drop_target = 0;
        resetn = 0; wpcir = 1; pcsource = 0; bpc = 0; rpc = 0; jpc = 0;
        imem_bus.ack = 0; imem_bus.rdata = 0;

        // Reset then zero-wait sequential fetch.
        step(0, 1, PCSRC_SEQ, 0, 1);
        step(0, 1, PCSRC_SEQ, 0, 1);
        for (int i = 0; i < 6; i++) step(1, 1, PCSRC_SEQ, 0, 1);
        after_edge();
        check("t1_pc", pc, 32'h18);

        // Branch taken at 0x40.
        guard = 0;
        while (m_pc != 32'h40 && guard < 64) begin
            step(1, 1, PCSRC_SEQ, 0, 1);
            guard++;
        end
        check("t2_reach", m_pc, 32'h40);
        step(1, 1, PCSRC_BR, 32'h100, 1);
        check("t2_flush", {31'b0, flush}, 32'h1);
        check("t2_ins", ins, mem_word(32'h40));
        after_edge();
        check("t2_pc", pc, 32'h100);
        step(1, 1, PCSRC_SEQ, 0, 1);
        check("t2_noflush", {31'b0, flush}, 32'h0);

        // Stall for three cycles at 0x20; pcsource must be ignored while stalled.
        step(1, 1, PCSRC_JMP, 32'h20, 1);
        for (int i = 0; i < 3; i++) step(1, 0, PCSRC_BR, 32'h700, 1);
        check("t3_req", {31'b0, imem_bus.req}, 32'h0);
        check("t3_ins", ins, mem_word(32'h20));
        check("t3_pc", pc, 32'h20);
        step(1, 1, PCSRC_SEQ, 0, 1);
        after_edge();
        check("t3_pc_rel", pc, 32'h24);

        // Three-cycle memory latency with a jump on the first wait cycle.
        step(1, 1, PCSRC_JMP, 32'h80, 1);
        step(1, 1, PCSRC_JMP, 32'h200, 0);
        step(1, 1, PCSRC_SEQ, 0, 0);
        step(1, 1, PCSRC_SEQ, 0, 1);
        check("t4_addr_old", imem_bus.addr, 32'h80);
        check("t4_ins_nop", ins, NOP_WORD);
        after_edge();
        check("t4_addr_new", imem_bus.addr, 32'h200);

        // Reset during a discard wait.
        step(1, 1, PCSRC_BR, 32'h300, 0);
        step(0, 1, PCSRC_SEQ, 0, 0);
        after_edge();
        check("t5_pc", pc, 32'h0);
        check("t5_req", {31'b0, imem_bus.req}, 32'h1);
        check("t5_addr", imem_bus.addr, 32'h0);

        // Ack every other cycle for ten cycles.
        for (int i = 0; i < 10; i++) step(1, 1, PCSRC_SEQ, 0, (i % 2) == 0);
        after_edge();
`ifdef PIPE_IF_PERF_EN
        check("t6_fetch", fetch_cnt, 32'd5);
        check("t6_bubble", bubble_cnt, 32'd5);
`endif
        check("t6_pc", pc, 32'h14);

        // Randomized traffic: stalls, redirects, latency and occasional reset.
        for (int i = 0; i < 400; i++) begin
            logic [1:0] src;
            src = ($urandom_range(0, 3) == 0) ? 2'($urandom_range(1, 3)) : PCSRC_SEQ;
            step($urandom_range(0, 99) != 0, $urandom_range(0, 3) != 0, src,
                 $urandom & 32'hFFFF_FFFC, $urandom_range(0, 1) == 1);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
